// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation, out-of-order writeback by tag,
// strictly in-order retirement, full flush after a mispredicted branch retires.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [REG_W-1:0]  alloc_rd,
    input  logic              alloc_regWrite,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_mispredict,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [REG_W-1:0]  commit_rd,
    output logic              commit_regWrite,
    output logic [DATA_W-1:0] commit_data,
    output logic              flush,
    output logic [TAG_W:0]    count,
    output logic              empty,
    output logic              full
);

    localparam logic [TAG_W:0]   DEPTH_CNT = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   ONE_CNT   = (TAG_W+1)'(1);
    localparam logic [TAG_W:0]   ZERO_CNT  = (TAG_W+1)'(0);
    localparam logic [TAG_W-1:0] ONE_TAG   = TAG_W'(1);
    localparam logic [TAG_W-1:0] ZERO_TAG  = TAG_W'(0);

    // Per-entry state
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [DEPTH-1:0]  misp_q, misp_d;
    logic [DEPTH-1:0]  regw_q, regw_d;
    logic [REG_W-1:0]  rd_q   [DEPTH];
    logic [REG_W-1:0]  rd_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    // Pointers, occupancy and flush pulse
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;
    logic              flush_q, flush_d;

    logic head_done_s;
    logic alloc_fire_s;
    logic commit_fire_s;
    logic misp_commit_s;

    // Handshake terms depend only on registered state so none of them loop
    // back through the inputs.
    assign head_done_s   = valid_q[head_q] && done_q[head_q];
    assign alloc_ready   = (count_q != DEPTH_CNT) && !flush_q &&
                           !(head_done_s && misp_q[head_q]);
    assign alloc_fire_s  = alloc_valid && alloc_ready;
    assign commit_fire_s = head_done_s && commit_ready;
    assign misp_commit_s = commit_fire_s && misp_q[head_q];

    assign alloc_tag       = tail_q;
    assign commit_valid    = head_done_s;
    assign commit_rd       = rd_q[head_q];
    assign commit_regWrite = regw_q[head_q];
    assign commit_data     = data_q[head_q];
    assign flush           = flush_q;
    assign count           = count_q;
    assign empty           = (count_q == ZERO_CNT);
    assign full            = (count_q == DEPTH_CNT);

    // Next-state: a mispredict retirement wipes everything and overrides any
    // same-cycle alloc/writeback; otherwise writeback, commit and alloc apply
    // independently (commit sees the pre-edge done bit).
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        misp_d  = misp_q;
        regw_d  = regw_q;
        rd_d    = rd_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        flush_d = 1'b0;
        if (misp_commit_s) begin
            valid_d = '0;
            done_d  = '0;
            misp_d  = '0;
            regw_d  = '0;
            rd_d    = '{default: '0};
            data_d  = '{default: '0};
            head_d  = ZERO_TAG;
            tail_d  = ZERO_TAG;
            count_d = ZERO_CNT;
            flush_d = 1'b1;
        end else begin
            if (wb_valid && !flush_q && valid_q[wb_tag]) begin
                done_d[wb_tag] = 1'b1;
                misp_d[wb_tag] = wb_mispredict;
                data_d[wb_tag] = wb_data;
            end else begin
                done_d = done_d;
            end
            if (commit_fire_s) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                misp_d[head_q]  = 1'b0;
                regw_d[head_q]  = 1'b0;
                rd_d[head_q]    = '0;
                data_d[head_q]  = '0;
                head_d          = head_q + ONE_TAG;
            end else begin
                head_d = head_q;
            end
            if (alloc_fire_s) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                misp_d[tail_q]  = 1'b0;
                regw_d[tail_q]  = alloc_regWrite;
                rd_d[tail_q]    = alloc_rd;
                data_d[tail_q]  = '0;
                tail_d          = tail_q + ONE_TAG;
            end else begin
                tail_d = tail_q;
            end
            if (alloc_fire_s && !commit_fire_s) begin
                count_d = count_q + ONE_CNT;
            end else if (!alloc_fire_s && commit_fire_s) begin
                count_d = count_q - ONE_CNT;
            end else begin
                count_d = count_q;
            end
        end
    end

    // State registers with asynchronous clear of every field.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            done_q  <= '0;
            misp_q  <= '0;
            regw_q  <= '0;
            rd_q    <= '{default: '0};
            data_q  <= '{default: '0};
            head_q  <= ZERO_TAG;
            tail_q  <= ZERO_TAG;
            count_q <= ZERO_CNT;
            flush_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            misp_q  <= misp_d;
            regw_q  <= regw_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            flush_q <= flush_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (DEPTH=16, DATA_W=64, REG_W=5).
module tb_reorder_buffer;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 64;
    localparam int REG_W  = 5;
    localparam int TAG_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [REG_W-1:0]  alloc_rd;
    logic              alloc_regWrite;
    logic [TAG_W-1:0]  alloc_tag;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;
    logic              wb_mispredict;
    logic              commit_valid;
    logic              commit_ready;
    logic [REG_W-1:0]  commit_rd;
    logic              commit_regWrite;
    logic [DATA_W-1:0] commit_data;
    logic              flush;
    logic [TAG_W:0]    count;
    logic              empty;
    logic              full;

    int n_checks = 0;
    int n_fails  = 0;

    reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_rd(alloc_rd), .alloc_regWrite(alloc_regWrite), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .wb_mispredict(wb_mispredict),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_rd(commit_rd), .commit_regWrite(commit_regWrite),
        .commit_data(commit_data), .flush(flush), .count(count),
        .empty(empty), .full(full)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        alloc_valid    = 1'b0;
        alloc_rd       = 5'd0;
        alloc_regWrite = 1'b0;
        wb_valid       = 1'b0;
        wb_tag         = 4'd0;
        wb_data        = 64'd0;
        wb_mispredict  = 1'b0;
        commit_ready   = 1'b0;
    endtask

    task automatic pulse_reset;
        idle_inputs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // Watchdog: the bench never waits on DUT events, but never let it hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        #3;
        // T1 reset state
        check_eq("t1_empty", empty, 1'b1);
        check_eq("t1_alloc_ready", alloc_ready, 1'b1);
        check_eq("t1_count", count, 5'd0);
        check_eq("t1_commit_valid", commit_valid, 1'b0);
        check_eq("t1_flush", flush, 1'b0);
        check_eq("t1_full", full, 1'b0);
        check_eq("t1_alloc_tag", alloc_tag, 4'd0);
        tick();
        reset = 1'b0;

        // T2 out-of-order writeback, in-order commit
        alloc_valid = 1'b1;
        alloc_regWrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alloc_rd = 5'(i + 1);
            check_eq("t2_alloc_tag", alloc_tag, 64'(i));
            tick();
        end
        alloc_valid = 1'b0;
        check_eq("t2_count3", count, 5'd3);
        wb_valid = 1'b1; wb_tag = 4'd2; wb_data = 64'hC;
        tick();
        check_eq("t2_cv_head_not_done", commit_valid, 1'b0);
        wb_tag = 4'd0; wb_data = 64'hA;
        check_eq("t2_cv_same_cycle_wb", commit_valid, 1'b0);
        tick();
        check_eq("t2_cv_after_wb", commit_valid, 1'b1);
        wb_tag = 4'd1; wb_data = 64'hB;
        tick();
        wb_valid = 1'b0;
        commit_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_commit_valid", commit_valid, 1'b1);
            check_eq("t2_commit_rd", commit_rd, 64'(i + 1));
            check_eq("t2_commit_data", commit_data, 64'hA + 64'(i));
            check_eq("t2_commit_regWrite", commit_regWrite, 1'b1);
            tick();
        end
        commit_ready = 1'b0;
        check_eq("t2_count0", count, 5'd0);
        check_eq("t2_empty", empty, 1'b1);

        // T3 fill to full (head=tail=3 here), overflow attempt, commit with alloc pending
        alloc_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            alloc_rd = 5'(i);
            check_eq("t3_alloc_tag", alloc_tag, 64'((3 + i) % 16));
            tick();
        end
        check_eq("t3_full", full, 1'b1);
        check_eq("t3_alloc_ready", alloc_ready, 1'b0);
        check_eq("t3_count16", count, 5'd16);
        tick();
        check_eq("t3_count_after_17th", count, 5'd16);
        check_eq("t3_tail_after_17th", alloc_tag, 4'd3);
        wb_valid = 1'b1; wb_tag = 4'd3; wb_data = 64'h33;
        tick();
        wb_valid = 1'b0;
        commit_ready = 1'b1;
        check_eq("t3_commit_data", commit_data, 64'h33);
        check_eq("t3_full_pre_commit", full, 1'b1);
        tick();
        check_eq("t3_count15", count, 5'd15);
        check_eq("t3_full_cleared", full, 1'b0);
        check_eq("t3_alloc_ready_back", alloc_ready, 1'b1);
        check_eq("t3_tail_held", alloc_tag, 4'd3);
        pulse_reset();

        // T4 head holds while commit_ready is low
        alloc_valid = 1'b1; alloc_rd = 5'd5; alloc_regWrite = 1'b1;
        tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 4'd0; wb_data = 64'h1234;
        tick();
        wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t4_cv_hold", commit_valid, 1'b1);
            check_eq("t4_rd_hold", commit_rd, 5'd5);
            check_eq("t4_data_hold", commit_data, 64'h1234);
            check_eq("t4_count_hold", count, 5'd1);
            tick();
        end
        commit_ready = 1'b1;
        tick();
        commit_ready = 1'b0;
        check_eq("t4_count_after", count, 5'd0);
        check_eq("t4_cv_after", commit_valid, 1'b0);
        pulse_reset();

        // T5 steady alloc + writeback + commit, occupancy held at 2
        alloc_valid = 1'b1; alloc_regWrite = 1'b1; alloc_rd = 5'd0;
        check_eq("t5_alloc_tag", alloc_tag, 4'd0);
        tick();
        alloc_rd = 5'd1;
        check_eq("t5_alloc_tag", alloc_tag, 4'd1);
        wb_valid = 1'b1; wb_tag = 4'd0; wb_data = 64'h100;
        tick();
        commit_ready = 1'b1;
        for (int i = 2; i < 20; i++) begin
            alloc_rd = 5'(i);
            wb_tag   = 4'((i - 1) % 16);
            wb_data  = 64'h100 + 64'(i - 1);
            check_eq("t5_alloc_tag", alloc_tag, 64'(i % 16));
            check_eq("t5_commit_valid", commit_valid, 1'b1);
            check_eq("t5_commit_data", commit_data, 64'h100 + 64'(i - 2));
            check_eq("t5_commit_rd", commit_rd, 64'(i - 2));
            tick();
            check_eq("t5_count", count, 5'd2);
        end
        pulse_reset();

        // T6 mispredicted branch retires -> flush
        alloc_valid = 1'b1; alloc_rd = 5'd0; alloc_regWrite = 1'b0;
        tick();
        alloc_regWrite = 1'b1; alloc_rd = 5'd7;
        tick();
        alloc_rd = 5'd8;
        tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 4'd0; wb_data = 64'h0; wb_mispredict = 1'b1;
        tick();
        wb_mispredict = 1'b0;
        check_eq("t6_alloc_ready_blocked", alloc_ready, 1'b0);
        check_eq("t6_cv_branch", commit_valid, 1'b1);
        commit_ready = 1'b1; alloc_valid = 1'b1;
        wb_tag = 4'd1; wb_data = 64'h55;
        tick();
        check_eq("t6_flush", flush, 1'b1);
        check_eq("t6_count", count, 5'd0);
        check_eq("t6_empty", empty, 1'b1);
        check_eq("t6_alloc_ready_flush", alloc_ready, 1'b0);
        check_eq("t6_cv_flush", commit_valid, 1'b0);
        commit_ready = 1'b0;
        tick();
        check_eq("t6_flush_gone", flush, 1'b0);
        check_eq("t6_count_post", count, 5'd0);
        check_eq("t6_alloc_ready_post", alloc_ready, 1'b1);
        check_eq("t6_tag_restart", alloc_tag, 4'd0);
        wb_valid = 1'b0;
        tick();
        alloc_valid = 1'b0;
        check_eq("t6_count_one", count, 5'd1);
        check_eq("t6_next_tag", alloc_tag, 4'd1);
        check_eq("t6_new_entry_not_done", commit_valid, 1'b0);
        pulse_reset();

        // T7 asynchronous reset mid-cycle with a pending writeback
        alloc_valid = 1'b1; alloc_regWrite = 1'b1; alloc_rd = 5'd3;
        for (int i = 0; i < 5; i++) tick();
        alloc_valid = 1'b0;
        check_eq("t7_count5", count, 5'd5);
        wb_valid = 1'b1; wb_tag = 4'd0; wb_data = 64'h77;
        #2;
        reset = 1'b1;
        #1;
        check_eq("t7_count_async", count, 5'd0);
        check_eq("t7_empty_async", empty, 1'b1);
        check_eq("t7_alloc_ready_async", alloc_ready, 1'b1);
        tick();
        reset = 1'b0;
        wb_valid = 1'b0;
        tick();
        check_eq("t7_cv_after", commit_valid, 1'b0);
        check_eq("t7_count_after", count, 5'd0);
        check_eq("t7_data_after", commit_data, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
